myfilter_mc_core: RTL and testbench

Parametrised, multi-channel, time-multiplexed FIR datapath for the myfilter design. It generalises the fixed five-tap sequencer to NTAPS taps, DATABITS-wide samples and NCH independent channels. The channels share one MAC and one coefficient set, and each channel has its own delay line. It sits between the external sample interface and the I2C-programmed coefficient register bank. It adds valid/ready handshaking on both sides, a synchronous clear and per-sample channel tagging.

---
 rtl/myfilter_mc_core.sv | 135 +++++++++++++
 tb/tb_myfilter_mc_core.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/myfilter_mc_core.sv
// Multi-channel time-multiplexed FIR: one shared MAC and coefficient set, one
// delay line per channel, valid/ready on both sides and saturating output.
module myfilter_mc_core #(
  parameter  int NTAPS    = 5,
  parameter  int DATABITS = 16,
  parameter  int NCH      = 2,
  localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int ACCBITS  = 2*DATABITS + $clog2(NTAPS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NTAPS*DATABITS-1:0]  coef_in,
  input  logic                       clear_in,
  input  logic                       extvalid_in,
  output logic                       extready_out,
  input  logic signed [DATABITS-1:0] extin,
  input  logic [CHW-1:0]             chan_in,
  output logic                       extvalid_out,
  input  logic                       extready_in,
  output logic [DATABITS-1:0]        extout,
  output logic [CHW-1:0]             chan_out,
  output logic                       busy_out,
  output logic [1:0]                 state_dbg
);

  localparam int TW = $clog2(NTAPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    SAT  = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; an offered output holds data and valid until it is taken.

  state_t                      state;
  logic [TW-1:0]               tap;
  logic [CHW-1:0]              chan_q;
  logic signed [ACCBITS-1:0]   acc;
  logic signed [DATABITS-1:0]  dline  [NCH][NTAPS];
  logic signed [DATABITS-1:0]  coef_q [NTAPS];

  logic signed [2*DATABITS-1:0] prod;
  logic signed [ACCBITS-1:0]    prod_ext;
  logic signed [ACCBITS-1:0]    shifted;
  logic [DATABITS-1:0]          sat_val;
  logic                         chan_ok;

  localparam logic signed [ACCBITS-1:0] SMAX =
    {{(ACCBITS-DATABITS+1){1'b0}}, {(DATABITS-1){1'b1}}};
  localparam logic signed [ACCBITS-1:0] SMIN =
    {{(ACCBITS-DATABITS+1){1'b1}}, {(DATABITS-1){1'b0}}};

  always_comb begin
    prod     = dline[chan_q][tap] * coef_q[tap];
    prod_ext = {{(ACCBITS-2*DATABITS){prod[2*DATABITS-1]}}, prod};
    shifted  = acc >>> (DATABITS-1);
    sat_val  = shifted[DATABITS-1:0];
    if (shifted > SMAX)
      sat_val = {1'b0, {(DATABITS-1){1'b1}}};
    else if (shifted < SMIN)
      sat_val = {1'b1, {(DATABITS-1){1'b0}}};
    chan_ok  = (32'(chan_in) < NCH);
  end

  assign extready_out = (state == IDLE) & ~clear_in & ~rst;
  assign busy_out     = (state != IDLE);
  assign state_dbg    = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tap          <= '0;
      acc          <= '0;
      chan_q       <= '0;
      extvalid_out <= 1'b0;
      extout       <= '0;
      chan_out     <= '0;
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < NTAPS; k++)
          dline[c][k] <= '0;
      for (int k = 0; k < NTAPS; k++)
        coef_q[k] <= '0;
    end else if (clear_in) begin
      // Clear beats both accept and output handshake; coefficients survive.
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < NTAPS; k++)
          dline[c][k] <= '0;
      acc          <= '0;
      tap          <= '0;
      extvalid_out <= 1'b0;
      state        <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          // Out-of-range channels are swallowed without touching any state.
          if (extvalid_in && chan_ok) begin
            for (int k = NTAPS-1; k > 0; k--)
              dline[chan_in][k] <= dline[chan_in][k-1];
            dline[chan_in][0] <= extin;
            for (int k = 0; k < NTAPS; k++)
              coef_q[k] <= coef_in[k*DATABITS +: DATABITS];
            chan_q <= chan_in;
            acc    <= '0;
            tap    <= '0;
            state  <= MAC;
          end
        end
        MAC: begin
          acc <= acc + prod_ext;
          if (tap == TW'(NTAPS-1))
            state <= SAT;
          else
            tap <= tap + TW'(1);
        end
        SAT: begin
          extout       <= sat_val;
          chan_out     <= chan_q;
          extvalid_out <= 1'b1;
          state        <= OUT;
        end
        OUT: begin
          if (extready_in) begin
            extvalid_out <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_myfilter_mc_core.sv
// Directed and randomized bench for myfilter_mc_core against a per-channel
// history model evaluated with plain integer arithmetic.
module tb_myfilter_mc_core;

  localparam int NTAPS    = 5;
  localparam int DATABITS = 16;
  localparam int NCH      = 3;
  localparam int CHW      = 2;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NTAPS*DATABITS-1:0]  coef_in;
  logic                       clear_in;
  logic                       extvalid_in;
  logic                       extready_out;
  logic signed [DATABITS-1:0] extin;
  logic [CHW-1:0]             chan_in;
  logic                       extvalid_out;
  logic                       extready_in;
  logic [DATABITS-1:0]        extout;
  logic [CHW-1:0]             chan_out;
  logic                       busy_out;
  logic [1:0]                 state_dbg;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] hist [NCH][NTAPS];
  logic signed [15:0] cf   [NTAPS];
  logic [DATABITS-1:0] exp_q [$];

  myfilter_mc_core #(.NTAPS(NTAPS), .DATABITS(DATABITS), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .coef_in(coef_in), .clear_in(clear_in),
    .extvalid_in(extvalid_in), .extready_out(extready_out), .extin(extin),
    .chan_in(chan_in), .extvalid_out(extvalid_out), .extready_in(extready_in),
    .extout(extout), .chan_out(chan_out), .busy_out(busy_out),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: output = clip(floor(sum(x[n-k]*c[k]) / 2^15)).
  function automatic logic [15:0] model_push(input int ch, input logic [15:0] x);
    longint s;
    for (int k = NTAPS-1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
    hist[ch][0] = x;
    s = 0;
    for (int k = 0; k < NTAPS; k++) s += longint'(hist[ch][k]) * longint'(cf[k]);
    s = s >>> 15;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < NTAPS; k++) hist[c][k] = '0;
  endtask

  task automatic set_coefs(input logic [15:0] c0, c1, c2, c3, c4);
    cf[0] = c0; cf[1] = c1; cf[2] = c2; cf[3] = c3; cf[4] = c4;
  endtask

  task automatic pulse_clear();
    clear_in = 1'b1;
    @(posedge clk); #1;
    clear_in = 1'b0;
    model_clear();
  endtask

  // Offer one sample (bounded wait for ready); afterwards scramble coef_in so
  // a missing coefficient latch would corrupt the in-flight result.
  task automatic drive_accept(input logic [15:0] x, input int ch, input string tag);
    int n = 0;
    for (int k = 0; k < NTAPS; k++) coef_in[k*DATABITS +: DATABITS] = cf[k];
    while (!extready_out && n < 30) begin @(posedge clk); #1; n++; end
    check({tag, "_ready"}, extready_out, 1'b1);
    extin = x; chan_in = ch[CHW-1:0]; extvalid_in = 1'b1;
    @(posedge clk); #1;
    extvalid_in = 1'b0;
    coef_in = {$urandom, $urandom, $urandom};
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!extvalid_out && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_lat"}, n, NTAPS+1);
  endtask

  task automatic run_sample(input logic [15:0] x, input int ch, input int hold, input string tag);
    logic [15:0] held;
    extready_in = (hold == 0);
    drive_accept(x, ch, tag);
    exp_q.push_back(model_push(ch, x));
    wait_valid(tag);
    held = exp_q.pop_front();
    check({tag, "_out"}, extout, held);
    check({tag, "_ch"}, chan_out, ch);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_bp_v"}, extvalid_out, 1'b1);
      check({tag, "_bp_d"}, extout, held);
      check({tag, "_bp_c"}, chan_out, ch);
      check({tag, "_bp_r"}, extready_out, 1'b0);
    end
    extready_in = 1'b1;
    @(posedge clk); #1;
    check({tag, "_hs_v"}, extvalid_out, 1'b0);
    check({tag, "_hs_r"}, extready_out, 1'b1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; clear_in = 1'b0; extvalid_in = 1'b0; extin = '0; chan_in = '0;
    extready_in = 1'b1; coef_in = '0;
    model_clear();
    set_coefs(16'h4000, 16'h2000, 16'h1000, 16'h0800, 16'h0400);
    repeat (2) @(negedge clk);
    check("rst_valid", extvalid_out, 1'b0);
    check("rst_out", extout, 16'h0);
    check("rst_chan", chan_out, 2'd0);
    check("rst_busy", busy_out, 1'b0);
    check("rst_ready", extready_out, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", extready_out, 1'b1);

    // Impulse response on channel 0.
    run_sample(16'h7FFF, 0, 0, "imp0");
    for (int i = 0; i < 5; i++) run_sample(16'h0000, 0, 0, "imp");

    // Channel isolation: ch1 zeros interleaved with a ch0 impulse.
    pulse_clear();
    run_sample(16'h7FFF, 0, 0, "iso0");
    for (int i = 0; i < 5; i++) begin
      run_sample(16'h0000, 1, 0, "iso1");
      run_sample(16'h0000, 0, 0, "iso0");
    end

    // Saturation both ways.
    pulse_clear();
    set_coefs(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    for (int i = 0; i < 5; i++) run_sample(16'h7FFF, 0, 0, "satp");
    pulse_clear();
    for (int i = 0; i < 5; i++) run_sample(16'h8000, 0, 0, "satn");

    // Backpressure for 10 cycles.
    pulse_clear();
    set_coefs(16'h4000, 16'h2000, 16'h1000, 16'h0800, 16'h0400);
    run_sample(16'h7FFF, 2, 10, "bp");

    // Clear during the second MAC cycle.
    pulse_clear();
    drive_accept(16'h7FFF, 0, "clr");
    @(posedge clk); #1;
    clear_in = 1'b1;
    @(posedge clk); #1;
    clear_in = 1'b0;
    check("clr_state", state_dbg, 2'd0);
    check("clr_busy", busy_out, 1'b0);
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (extvalid_out) seen++; end
    check("clr_novalid", seen, 0);
    model_clear();
    run_sample(16'h7FFF, 0, 0, "clr_rerun");
    clear_in = 1'b1; extvalid_in = 1'b1; extin = 16'h1234; chan_in = 2'd0;
    #1;
    check("clrv_ready", extready_out, 1'b0);
    @(posedge clk); #1;
    clear_in = 1'b0; extvalid_in = 1'b0;
    check("clrv_busy", busy_out, 1'b0);
    model_clear();

    // Illegal channel is dropped.
    drive_accept(16'h7FFF, 3, "ill");
    check("ill_busy", busy_out, 1'b0);
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (extvalid_out) seen++; end
    check("ill_novalid", seen, 0);
    run_sample(16'h7FFF, 0, 0, "ill_imp");

    // Randomized run with random coefficients, channels and backpressure.
    for (int i = 0; i < 30; i++) begin
      if (i % 5 == 0)
        set_coefs(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      run_sample(16'($urandom), $urandom_range(0, NCH-1), $urandom_range(0, 3), "rnd");
    end

    // Asynchronous reset while an output is pending.
    extready_in = 1'b0;
    drive_accept(16'h4321, 1, "arst");
    wait_valid("arst");
    #2 rst = 1'b1;
    #1;
    check("arst_valid", extvalid_out, 1'b0);
    check("arst_out", extout, 16'h0);
    check("arst_busy", busy_out, 1'b0);
    check("arst_ready", extready_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int k = 0; k < NTAPS; k++) cf[k] = '0;
    set_coefs(16'h4000, 16'h2000, 16'h1000, 16'h0800, 16'h0400);
    @(posedge clk); #1;
    run_sample(16'h7FFF, 0, 0, "arst_imp");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
